// File: rtl/alu_cmd_issuer_pkg.sv
// Shared encodings for the ALU command issuer and the ALU control block:
// opcode values, legal-opcode limit, default opcode width and FSM states.
package alu_cmd_issuer_pkg;

    localparam int unsigned OP_W_DEFAULT = 5;
    localparam int unsigned DATA_W       = 4;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned ISSUED_W     = 8;

    localparam logic [OP_W_DEFAULT-1:0] OP_ADD   = 5'd0;
    localparam logic [OP_W_DEFAULT-1:0] OP_SUB   = 5'd1;
    localparam logic [OP_W_DEFAULT-1:0] OP_AND   = 5'd2;
    localparam logic [OP_W_DEFAULT-1:0] OP_OR    = 5'd3;
    localparam logic [OP_W_DEFAULT-1:0] OP_XOR   = 5'd4;
    localparam logic [OP_W_DEFAULT-1:0] OP_XNOR  = 5'd5;
    localparam logic [OP_W_DEFAULT-1:0] OP_NAND  = 5'd6;
    localparam logic [OP_W_DEFAULT-1:0] OP_NOR   = 5'd7;
    localparam logic [OP_W_DEFAULT-1:0] OP_NOT   = 5'd8;
    localparam logic [OP_W_DEFAULT-1:0] OP_SHIFT = 5'd9;
    localparam logic [OP_W_DEFAULT-1:0] OP_MULT  = 5'd10;

    localparam int unsigned OP_LAST = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and response signals of the issuer; master is the
// environment (front end + ALU), slave is the issuer itself.
interface alu_cmd_if
    import alu_cmd_issuer_pkg::*;
#(
    parameter int unsigned OP_W = OP_W_DEFAULT
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_x;
    logic [DATA_W-1:0] cmd_y;
    logic              cmd_cin;

    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic              alu_cin;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_cout;
    logic [OP_W-1:0]   rsp_op;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_cin,
        input  cmd_ready,
        input  alu_op, alu_x, alu_y, alu_cin,
        output alu_result, alu_cout,
        input  rsp_valid, rsp_result, rsp_cout, rsp_op, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_cin,
        output cmd_ready,
        output alu_op, alu_x, alu_y, alu_cin,
        input  alu_result, alu_cout,
        output rsp_valid, rsp_result, rsp_cout, rsp_op, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_cmd_issuer_fifo.sv
// Synchronous command FIFO; the head is only visible once the entry is
// registered, so nothing passes through in the push cycle.
module alu_cmd_fifo
    import alu_cmd_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = OP_W_DEFAULT + 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, drives them onto the ALU for a settle time, and
// returns the captured result (or an illegal-opcode error) as a response.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned OP_W          = OP_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_if.slave            bus,
    output logic                busy,
    output logic [ISSUED_W-1:0] issued_count
);
    localparam int unsigned ENTRY_W = OP_W + 2 * DATA_W + 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_settle;
    logic [OP_W-1:0]     r_alu_op;
    logic [DATA_W-1:0]   r_alu_x;
    logic [DATA_W-1:0]   r_alu_y;
    logic                r_alu_cin;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_result;
    logic                r_rsp_cout;
    logic [OP_W-1:0]     r_rsp_op;
    logic                r_rsp_err;
    logic [ISSUED_W-1:0] r_issued;

    logic [ENTRY_W-1:0]  w_head;
    logic [OP_W-1:0]     w_head_op;
    logic [DATA_W-1:0]   w_head_x;
    logic [DATA_W-1:0]   w_head_y;
    logic                w_head_cin;
    logic                w_head_legal;
    logic                w_full;
    logic                w_empty;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                w_pop;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid),
        .i_data  ({bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_cin}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign {w_head_op, w_head_x, w_head_y, w_head_cin} = w_head;
    assign w_head_legal = (32'(w_head_op) <= OP_LAST);

    // Pop from IDLE, or back-to-back as the current response is accepted.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready));

    assign bus.cmd_ready  = !w_full;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_x      = r_alu_x;
    assign bus.alu_y      = r_alu_y;
    assign bus.alu_cin    = r_alu_cin;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_cout   = r_rsp_cout;
    assign bus.rsp_op     = r_rsp_op;
    assign bus.rsp_err    = r_rsp_err;
    assign issued_count   = r_issued;
    assign busy           = (r_state != IDLE) || (w_fifo_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_settle     <= '0;
            r_alu_op     <= '0;
            r_alu_x      <= '0;
            r_alu_y      <= '0;
            r_alu_cin    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_op     <= '0;
            r_rsp_err    <= 1'b0;
            r_issued     <= '0;
        end else if (w_pop) begin
            if (w_head_legal) begin
                r_alu_op    <= w_head_op;
                r_alu_x     <= w_head_x;
                r_alu_y     <= w_head_y;
                r_alu_cin   <= w_head_cin;
                r_settle    <= CNT_W'(SETTLE_CYCLES - 1);
                r_rsp_valid <= 1'b0;
                r_state     <= DRIVE;
            end else begin
                // Illegal opcode never reaches the ALU; answer directly.
                r_rsp_valid  <= 1'b1;
                r_rsp_err    <= 1'b1;
                r_rsp_result <= '0;
                r_rsp_cout   <= 1'b0;
                r_rsp_op     <= w_head_op;
                r_state      <= RESP;
            end
        end else begin
            case (r_state)
                DRIVE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - CNT_W'(1);
                    end else begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= 1'b0;
                        r_rsp_result <= bus.alu_result;
                        r_rsp_cout   <= bus.alu_cout;
                        r_rsp_op     <= r_alu_op;
                        r_issued     <= r_issued + ISSUED_W'(1);
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the 4-bit ALU operation interface.
- Accepts queued ALU commands over a valid/ready port and drives operands, carry-in and opcode to the ALU datapath.
- Holds them stable for a programmable settle time, captures the result and carry-out, and returns them over a valid/ready response port.
- Sits between the test/control front end and the combinational ALU.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, 2..16).
- SETTLE_CYCLES, 1, cycles operands are held on the ALU before sampling (1..15).
- OP_W, 5, opcode width, matching the ALU Operation port.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  OP_W  opcode.
- cmd_x  in  4  operand x.
- cmd_y  in  4  operand y.
- cmd_cin  in  1  carry-in.
- alu_op  out  OP_W  registered opcode to the ALU.
- alu_x  out  4  registered operand x to the ALU.
- alu_y  out  4  registered operand y to the ALU.
- alu_cin  out  1  registered carry-in to the ALU.
- alu_result  in  4  ALU result.
- alu_cout  in  1  ALU carry-out.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  4  captured result.
- rsp_cout  out  1  captured carry-out.
- rsp_op  out  OP_W  opcode that produced the response.
- rsp_err  out  1  opcode was illegal; ALU was not exercised.
- busy  out  1  state != IDLE or FIFO non-empty.
- issued_count  out  8  legal operations completed; wraps at 255 -> 0.

Behaviour:
- Reset: synchronous, active-high on rst. All outputs 0. FIFO emptied. State = IDLE. Settle counter 0.
- Reset mid-operation: an in-flight or pending response is discarded, no handshake completes, and all queued commands are lost.
- FIFO push: on cmd_valid && cmd_ready.
- FIFO pop: on the state machine's pop request.
- FIFO full: cmd_ready = 0. A command presented while full is not accepted and must be held by the source.
- Simultaneous push and pop: legal when not full; occupancy is unchanged.
- No pass-through: a command pushed into an empty FIFO is popped no earlier than the next cycle.
- Legal opcodes, values 0..10: ADD, SUB, AND, OR, XOR, XNOR, NAND, NOR, NOT, SHIFT, MULT. Values 11 and above are illegal.
- State machine, state IDLE:
  - If the FIFO is non-empty: pop the head.
  - Legal opcode: register alu_op/alu_x/alu_y/alu_cin, load settle counter = SETTLE_CYCLES-1, go to DRIVE.
  - Illegal opcode: ALU outputs unchanged; rsp_err=1, rsp_result=0, rsp_cout=0, rsp_op=opcode; go to RESP.
- State machine, state DRIVE:
  - While the counter is non-zero: decrement it; ALU outputs held.
  - When the counter is 0: capture alu_result/alu_cout into rsp_result/rsp_cout, rsp_op=alu_op, rsp_err=0, increment issued_count, go to RESP.
- State machine, state RESP:
  - rsp_valid=1; rsp_* held stable until the handshake.
  - On rsp_ready with FIFO non-empty: pop and load as in IDLE in the same cycle (back-to-back), going to DRIVE or RESP.
  - On rsp_ready with FIFO empty: go to IDLE.
  - Without rsp_ready: stay in RESP.
- Latency for a legal command:
  - Popped in cycle t.
  - ALU inputs valid from t+1.
  - Result sampled at the end of cycle t+SETTLE_CYCLES.
  - rsp_valid asserted from t+SETTLE_CYCLES+1.
- Throughput: one legal operation per SETTLE_CYCLES+1 cycles with rsp_ready held high.
- ALU outputs keep their last value while in IDLE, so the ALU is not toggled needlessly.
- Widths: result and carry are taken verbatim from the ALU. MULT returns the low 4 bits, as the ALU defines it. The issuer performs no arithmetic except the counters.

Decomposition:
- Shared header alu_ops.vh holds:
  - opcode defines OP_ADD..OP_MULT (0..10);
  - OP_LAST = 10;
  - OP_W default;
  - state encodings IDLE=0, DRIVE=1, RESP=2.
- The ALU control block includes the same header, so the two ends agree on encoding.
- Sub-module alu_cmd_fifo:
  - synchronous DEPTH-entry FIFO, entry width OP_W+9;
  - push/pop interface with full, empty and count outputs;
  - same clk/rst.

Test Plan:
- Single ADD, x=4'h3 y=4'h5 cin=0, rsp_ready=1, SETTLE_CYCLES=1 -> alu_x=3 / alu_y=5 one cycle after pop; rsp_valid two cycles after pop; rsp_result=4'h8, rsp_cout=0, rsp_err=0; issued_count=1.
- ADD overflow, x=4'hF y=4'h1 cin=0 -> rsp_result=4'h0, rsp_cout=1, rsp_op=0.
- Illegal opcode 5'd20 -> rsp_valid one cycle after pop; rsp_err=1, rsp_result=0; alu_* unchanged; issued_count unchanged.
- Backpressure, rsp_ready=0, push 6 commands (DEPTH=4):
  - first command reaches RESP; next 4 fill the FIFO; cmd_ready=0 with the 6th held;
  - releasing rsp_ready drains all 6 in order with no loss;
  - back-to-back spacing is 2 cycles per legal op.
- Reset asserted during DRIVE with 3 commands queued -> next cycle: rsp_valid=0, busy=0, cmd_ready=1, issued_count=0, all alu_* outputs = 0.
- Counter wrap: 256 legal ops -> issued_count returns to 0 with no glitch on rsp_* stability.
